// File: rtl/param_reg_file_if.sv
// Register-file access bus: write control (FunSel/RegSel/I), read selects,
// and the read data plus per-register status flags.
interface param_reg_file_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]       FunSel;
  logic [DEPTH-1:0] RegSel;
  logic [WIDTH-1:0] I;
  logic [SW-1:0]    OutASel;
  logic [SW-1:0]    OutBSel;
  logic [WIDTH-1:0] OutA;
  logic [WIDTH-1:0] OutB;
  logic [DEPTH-1:0] Zero;
  logic [DEPTH-1:0] Evt;

  // No valid/ready: every write applies on each rising edge where its RegSel bit is low,
  // and reads are purely combinational.
  modport master (
    output FunSel, RegSel, I, OutASel, OutBSel,
    input  OutA, OutB, Zero, Evt
  );

  modport slave (
    input  FunSel, RegSel, I, OutASel, OutBSel,
    output OutA, OutB, Zero, Evt
  );
endinterface

// File: rtl/param_reg_file.sv
// Parametrised register file with per-register dec/inc/load/clear, zero flags,
// sticky wrap/clamp event flags and an optional next-value read bypass.
module param_reg_file #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int SAT    = 0,
  parameter int BYPASS = 0
) (
  input  logic              CLK,
  input  logic              RST,
  param_reg_file_if.slave   bus
);
  localparam logic [1:0] FN_DEC = 2'd0;
  localparam logic [1:0] FN_INC = 2'd1;
  localparam logic [1:0] FN_LD  = 2'd2;
  localparam logic [1:0] FN_CLR = 2'd3;

  logic [WIDTH-1:0] regs     [DEPTH];
  logic [WIDTH-1:0] nxt      [DEPTH];
  logic [DEPTH-1:0] evt_q;
  logic [DEPTH-1:0] evt_nxt;
  logic [DEPTH-1:0] zero_flags;

  // Next state for every register; also feeds the bypassed read ports.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      nxt[k]     = regs[k];
      evt_nxt[k] = evt_q[k];
      if (RST) begin
        nxt[k]     = '0;
        evt_nxt[k] = 1'b0;
      end else if (!bus.RegSel[k]) begin
        case (bus.FunSel)
          FN_DEC: begin
            if (regs[k] == '0) begin
              nxt[k]     = (SAT != 0) ? '0 : '1;
              evt_nxt[k] = 1'b1;
            end else begin
              nxt[k] = regs[k] - 1'b1;
            end
          end
          FN_INC: begin
            if (regs[k] == '1) begin
              nxt[k]     = (SAT != 0) ? '1 : '0;
              evt_nxt[k] = 1'b1;
            end else begin
              nxt[k] = regs[k] + 1'b1;
            end
          end
          FN_LD: nxt[k] = bus.I;
          default: begin
            nxt[k]     = '0;
            evt_nxt[k] = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
      evt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= nxt[k];
      evt_q <= evt_nxt;
    end
  end

  always_comb begin
    zero_flags = '0;
    for (int k = 0; k < DEPTH; k++) zero_flags[k] = (regs[k] == '0);
  end

  // Zero always reflects stored contents, even when the read ports are bypassed.
  assign bus.Zero = zero_flags;
  assign bus.Evt  = evt_q;
  assign bus.OutA = (BYPASS != 0) ? nxt[bus.OutASel] : regs[bus.OutASel];
  assign bus.OutB = (BYPASS != 0) ? nxt[bus.OutBSel] : regs[bus.OutBSel];
endmodule
